// File: rtl/ram_param_delayn.sv
// Purpose: parametrised single-port synchronous RAM with byte-enabled writes and a post-reset zero-fill sweep.
// Latency: a read accepted on edge N drives readdata/readdatavalid on edge N+READ_LATENCY-1; writes commit on the accepting edge.
// Backpressure: waitrequest is high only during the sweep, when requests are dropped rather than queued; otherwise one read and/or write is accepted per cycle.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   address, write, read   - word address and request strobes (accepted when waitrequest is low)
//   byteenable, writedata  - per-byte write mask and write data
//   waitrequest            - requests not accepted this cycle (sweep in progress)
//   readdata, readdatavalid- read result and its one-cycle strobe
module ram_param_delayn #(
    parameter int    DATA_WIDTH     = 16,
    parameter int    ADDR_WIDTH     = 12,
    parameter int    READ_LATENCY   = 1,
    parameter bit    RDW_NEW        = 1'b1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string RAM_INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    write,
    input  logic                    read,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // A preloaded image must never be wiped, so a named init file overrides the sweep.
    localparam bit SWEEP_EN = CLEAR_ON_RESET && (RAM_INIT_FILE == "");

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    // Memory write port, shared between the sweep and normal writes.
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [BE_W-1:0]         mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdat;
    logic [DATA_WIDTH-1:0]   mem_rdat;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    wr_acc;
    logic                    rd_acc;

    // Read pipeline; stage READ_LATENCY-1 is the output register.
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Control FSM: sweep every word once, then serve requests.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_addr = address;
        mem_be   = byteenable;
        mem_wdat = writedata;
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_be   = '1;
                mem_wdat = '0;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                wr_acc = write;
                rd_acc = read;
                mem_we = write;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign waitrequest = (state_q == ST_CLEAR);

    // Single address port: a read and a write on the same edge always hit the same word.
    assign mem_rdat = mem[address];

    always_comb begin
        merged = mem_rdat;
        for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
                merged[8*i +: 8] = writedata[8*i +: 8];
            end
        end
        rd_word = (RDW_NEW && wr_acc) ? merged : mem_rdat;
    end

    // Data registers only load when a valid read reaches them, so readdata
    // holds its last value across idle cycles.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? rd_word : dat_q[0];
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP_EN ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            vld_q   <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // Storage has no reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdat[8*i +: 8];
                end
            end
        end
    end

    assign readdata      = dat_q[READ_LATENCY-1];
    assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule
